// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc: multi-cycle Hack CPU with request/acknowledge instruction and
// data ports. Each instruction walks FETCH -> DECODE -> [MREAD] -> EXEC ->
// [MWRITE]. A handshake state holds its request until ack is seen.
module hack_cpu_mc #(
  parameter int                WIDTH        = 16,
  parameter int                ADDR_W       = 15,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WIDTH-1:0]  imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [WIDTH-1:0]  dmem_wdata,
  input  logic              dmem_ack,
  input  logic [WIDTH-1:0]  dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              retire
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_MREAD, S_EXEC, S_MWRITE
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d, d_q, d_d, ir_q, ir_d, mdr_q, mdr_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, waddr_q, waddr_d;

  logic                fetch_req, data_req, data_we, retire_c;
  logic [WIDTH-1:0]    alu_x, alu_y, alu_out;
  logic                zr, ng, jump;

  // C-instruction fields sit at fixed bit positions regardless of WIDTH.
  logic is_c, a_sel, d1, d2, d3;
  assign is_c  = ir_q[WIDTH-1];
  assign a_sel = ir_q[12];
  assign d1    = ir_q[5];
  assign d2    = ir_q[4];
  assign d3    = ir_q[3];

  // ALU over the pre-update A/D (and MDR for M operands).
  always_comb begin
    alu_x = ir_q[11] ? '0 : d_q;
    if (ir_q[10]) alu_x = ~alu_x;
    alu_y = ir_q[9] ? '0 : (a_sel ? mdr_q : a_q);
    if (ir_q[8]) alu_y = ~alu_y;
    alu_out = ir_q[7] ? (alu_x + alu_y) : (alu_x & alu_y);
    if (ir_q[6]) alu_out = ~alu_out;
  end

  assign zr   = (alu_out == '0);
  assign ng   = alu_out[WIDTH-1];
  assign jump = (ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~zr & ~ng);

  // Next-state and next-register values; handshake outputs decoded from state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    a_d       = a_q;
    d_d       = d_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    fetch_req = 1'b0;
    data_req  = 1'b0;
    data_we   = 1'b0;
    retire_c  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!is_c) begin
          a_d      = {1'b0, ir_q[WIDTH-2:0]};
          pc_d     = pc_q + ADDR_W'(1);
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (a_sel) begin
          state_d = S_MREAD;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_MREAD: begin
        data_req = 1'b1;
        if (dmem_ack) begin
          mdr_d   = dmem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (d1) a_d = alu_out;
        if (d2) d_d = alu_out;
        pc_d = jump ? a_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
        if (d3) begin
          // Capture target and data now so MWRITE is independent of later A/D.
          waddr_d = a_q[ADDR_W-1:0];
          wdata_d = alu_out;
          state_d = S_MWRITE;
        end else begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_MWRITE: begin
        data_req = 1'b1;
        data_we  = 1'b1;
        if (dmem_ack) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural and bus-holding registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so all registers sample the same pre-edge values.
    if (!reset_n) begin
      // NOTE: every register here is reset; there is no memory array, so nothing is left unreset.
      state_q <= S_FETCH;
      a_q     <= '0;
      d_q     <= '0;
      pc_q    <= RESET_VECTOR;
      ir_q    <= '0;
      mdr_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      d_q     <= d_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Reset parks the FSM in FETCH, so requests are gated to stay low while reset_n=0.
  assign imem_req   = fetch_req & reset_n;
  assign dmem_req   = data_req & reset_n;
  assign dmem_we    = data_we & reset_n;
  assign retire     = retire_c & reset_n;
  assign imem_addr  = pc_q;
  assign dmem_addr  = (state_q == S_MWRITE) ? waddr_q : a_q[ADDR_W-1:0];
  assign dmem_wdata = wdata_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: an instruction-level model of the Hack ISA predicts
// every fetch address, data access, retire timing and PC, while wait-state
// memories respond with random or fixed latencies. A second, 24-bit instance
// runs a short program that exercises the width generalisation.
`timescale 1ns/1ps
module tb_hack_cpu_mc;
  localparam int W   = 16;
  localparam int AW  = 15;
  localparam int WW  = 24;
  localparam int WAW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, reset_w;
  logic          imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire;
  logic [AW-1:0] imem_addr, dmem_addr, pc;
  logic [W-1:0]  imem_rdata, dmem_wdata, dmem_rdata;

  logic           imem_req_w, imem_ack_w, dmem_req_w, dmem_we_w, dmem_ack_w, retire_w;
  logic [WAW-1:0] imem_addr_w, dmem_addr_w, pc_w;
  logic [WW-1:0]  imem_rdata_w, dmem_wdata_w, dmem_rdata_w;

  hack_cpu_mc #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .pc(pc), .retire(retire)
  );

  hack_cpu_mc #(.WIDTH(WW), .ADDR_W(WAW)) dut_w (
    .clk(clk), .reset_n(reset_w),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
    .dmem_req(dmem_req_w), .dmem_we(dmem_we_w), .dmem_addr(dmem_addr_w), .dmem_wdata(dmem_wdata_w),
    .dmem_ack(dmem_ack_w), .dmem_rdata(dmem_rdata_w), .pc(pc_w), .retire(retire_w)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] qget(input logic [63:0] q[$], input int i);
    return (i < q.size()) ? q[i] : '1;
  endfunction

  function automatic logic [63:0] wr_ent(input logic [31:0] addr, input logic [31:0] data);
    return {addr, data};
  endfunction

  // ---------------- memories and responder for the 16-bit instance
  logic [W-1:0] imem [0:(1<<AW)-1];
  logic [W-1:0] dmem [0:(1<<AW)-1];
  int i_wmin = 0, i_wmax = 0, d_wmin = 0, d_wmax = 0;
  bit spurious = 1'b0;

  initial begin
    int i_cnt, d_cnt;
    bit i_busy, d_busy;
    i_busy = 1'b0; d_busy = 1'b0; i_cnt = 0; d_cnt = 0;
    imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (imem_req) begin
        if (!i_busy) begin i_busy = 1'b1; i_cnt = $urandom_range(i_wmax, i_wmin); end
        if (i_cnt == 0) begin
          imem_ack = 1'b1; imem_rdata = imem[imem_addr]; i_busy = 1'b0;
        end else begin
          imem_ack = 1'b0; imem_rdata = W'($urandom); i_cnt--;
        end
      end else begin
        i_busy = 1'b0;
        imem_ack = spurious && ($urandom_range(3, 0) == 0);
        imem_rdata = W'($urandom);
      end
      if (dmem_req) begin
        if (!d_busy) begin d_busy = 1'b1; d_cnt = $urandom_range(d_wmax, d_wmin); end
        if (d_cnt == 0) begin
          dmem_ack = 1'b1; d_busy = 1'b0;
          if (dmem_we) begin dmem[dmem_addr] = dmem_wdata; dmem_rdata = W'($urandom); end
          else dmem_rdata = dmem[dmem_addr];
        end else begin
          dmem_ack = 1'b0; dmem_rdata = W'($urandom); d_cnt--;
        end
      end else begin
        d_busy = 1'b0;
        dmem_ack = spurious && ($urandom_range(3, 0) == 0);
        dmem_rdata = W'($urandom);
      end
    end
  end

  // ---------------- instruction-level reference model
  logic [W-1:0]  m_a, m_d, exp_wr_data;
  logic [AW-1:0] m_pc, exp_rd_addr, exp_wr_addr;
  bit            exp_rd, exp_wr, inflight;
  int            base;

  task automatic model_exec();
    logic [W-1:0] ir, x, y, o;
    logic zr, ng, jmp;
    ir = imem[m_pc];
    exp_rd = 1'b0;
    exp_wr = 1'b0;
    if (!ir[15]) begin
      m_a  = {1'b0, ir[14:0]};
      m_pc = m_pc + 1'b1;
      base = 2;
    end else begin
      x = ir[11] ? 16'h0 : m_d;
      if (ir[10]) x = ~x;
      y = ir[9] ? 16'h0 : (ir[12] ? dmem[m_a[14:0]] : m_a);
      if (ir[8]) y = ~y;
      o = ir[7] ? x + y : x & y;
      if (ir[6]) o = ~o;
      zr  = (o == 16'h0);
      ng  = o[15];
      jmp = (ir[2] && ng) || (ir[1] && zr) || (ir[0] && !zr && !ng);
      exp_rd = ir[12]; exp_rd_addr = m_a[14:0];
      exp_wr = ir[3];  exp_wr_addr = m_a[14:0]; exp_wr_data = o;
      m_pc = jmp ? m_a[14:0] : m_pc + 1'b1;
      if (ir[5]) m_a = o;
      if (ir[4]) m_d = o;
      base = 3 + int'(ir[12]) + int'(ir[3]);
    end
  endtask

  // ---------------- compare process (every cycle, on the falling edge)
  logic [63:0] retire_log[$], wr_log[$], fetch_log[$], pc_log[$];
  int  cyc_rel, inst_cyc, waits, n_retire = 0, d_rd_cyc, d_wr_cyc;
  bit  pc_next, hold_i, hold_d, prev_we;
  logic [AW-1:0] prev_iaddr, prev_daddr;
  logic [W-1:0]  prev_wdata;

  always @(negedge clk) begin
    if (!reset_n) begin
      check("reset_outputs_low", {imem_req, dmem_req, dmem_we, retire}, 4'b0000);
      m_a = '0; m_d = '0; m_pc = '0; inflight = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0;
      cyc_rel = 0; inst_cyc = 0; waits = 0; pc_next = 1'b0; hold_i = 1'b0; hold_d = 1'b0;
      d_rd_cyc = 0; d_wr_cyc = 0;
    end else begin
      cyc_rel++;
      inst_cyc++;
      pc_log.push_back(64'(pc));
      if (pc_next) begin check("pc_after_retire", pc, m_pc); pc_next = 1'b0; end
      check("req_exclusive", imem_req & dmem_req, 1'b0);
      if (hold_i) check("imem_hold", {imem_req, imem_addr}, {1'b1, prev_iaddr});
      if (hold_d)
        check("dmem_hold", {dmem_req, dmem_we, dmem_addr, dmem_we ? dmem_wdata : 16'h0},
              {1'b1, prev_we, prev_daddr, prev_we ? prev_wdata : 16'h0});
      if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)) waits++;
      if (dmem_req && !dmem_we) d_rd_cyc++;
      if (dmem_req && dmem_we) d_wr_cyc++;
      if (imem_req && imem_ack) begin
        check("fetch_when_idle", inflight, 1'b0);
        check("fetch_addr", imem_addr, m_pc);
        fetch_log.push_back(64'(imem_addr));
        model_exec();
        inflight = 1'b1;
      end
      if (dmem_req && dmem_ack) begin
        if (!dmem_we) begin
          check("read_expected", {exp_rd, dmem_addr}, {1'b1, exp_rd_addr});
          exp_rd = 1'b0;
        end else begin
          check("write_expected", {exp_wr, exp_rd, dmem_addr, dmem_wdata},
                {1'b1, 1'b0, exp_wr_addr, exp_wr_data});
          exp_wr = 1'b0;
          wr_log.push_back(wr_ent(32'(dmem_addr), 32'(dmem_wdata)));
        end
      end
      if (retire) begin
        check("retire_complete", {inflight, exp_rd, exp_wr}, 3'b100);
        check("inst_cycles", inst_cyc, base + waits);
        retire_log.push_back(64'(cyc_rel));
        n_retire++;
        inflight = 1'b0; inst_cyc = 0; waits = 0; pc_next = 1'b1;
      end
      hold_i = imem_req && !imem_ack; prev_iaddr = imem_addr;
      hold_d = dmem_req && !dmem_ack; prev_daddr = dmem_addr;
      prev_we = dmem_we; prev_wdata = dmem_wdata;
    end
  end

  // ---------------- 24-bit instance: zero-wait memory, fixed program
  logic [WW-1:0] wprog [int];
  logic [63:0]   wwr_log[$];

  function automatic logic [WW-1:0] c24(input logic [15:0] enc);
    // Bits 22..13 are junk on purpose: the CPU must ignore them.
    return 24'h800000 | 24'h356000 | {11'b0, enc[12:0]};
  endfunction

  initial begin
    reset_w = 1'b0;
    imem_ack_w = 1'b0; dmem_ack_w = 1'b0; imem_rdata_w = '0; dmem_rdata_w = '0;
    wprog[0] = 24'h7FFFFF;   wprog[1] = c24(16'hEC10);   // A=0x7FFFFF, D=A
    wprog[2] = 24'h000010;   wprog[3] = c24(16'hE308);   // M[0x10]=D
    wprog[4] = c24(16'hE7D0);                            // D=D+1
    wprog[5] = 24'h000011;   wprog[6] = c24(16'hE308);   // M[0x11]=D
    wprog[7] = 24'h000020;   wprog[8] = c24(16'hE304);   // D;JLT -> 0x20
    wprog[32] = 24'h000012;  wprog[33] = c24(16'hEE88);  // M[0x12]=-1
    wprog[34] = 24'h000022;  wprog[35] = c24(16'hEA87);  // 0;JMP self
    repeat (2) @(posedge clk);
    #1 reset_w = 1'b1;
    forever begin
      @(posedge clk); #2;
      imem_ack_w   = imem_req_w;
      imem_rdata_w = wprog.exists(int'(imem_addr_w)) ? wprog[int'(imem_addr_w)] : '0;
      dmem_ack_w   = dmem_req_w;
      dmem_rdata_w = '0;
    end
  end

  always @(negedge clk)
    if (reset_w && dmem_req_w && dmem_ack_w && dmem_we_w)
      wwr_log.push_back(wr_ent(32'(dmem_addr_w), 32'(dmem_wdata_w)));

  // ---------------- directed and random stimulus
  task automatic clear_mem();
    for (int i = 0; i < (1 << AW); i++) begin imem[i] = '0; dmem[i] = '0; end
  endtask

  task automatic enter_reset();
    @(negedge clk); #1 reset_n = 1'b0;
    retire_log.delete(); wr_log.delete(); fetch_log.delete(); pc_log.delete();
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    bit found;
    int n0;
    logic [63:0] exp_fetch [8];
    reset_n = 1'b0;

    // Reset state and first fetch; A-instruction then D=A, then M[100]=D.
    clear_mem();
    imem[0] = 16'h0005; imem[1] = 16'hEC10; imem[2] = 16'h0064; imem[3] = 16'hE308;
    repeat (2) @(negedge clk);
    check("t1_imem_req_in_reset", imem_req, 1'b0);
    check("t1_dmem_req_in_reset", {dmem_req, dmem_we}, 2'b00);
    check("t1_retire_in_reset", retire, 1'b0);
    check("t1_pc_in_reset", pc, 15'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("t1_first_fetch", {imem_req, imem_addr}, {1'b1, 15'd0});
    repeat (14) @(negedge clk);
    check("t2_retire0_cycle", qget(retire_log, 0), 64'd2);
    check("t2_retire1_cycle", qget(retire_log, 1), 64'd5);
    check("t2_pc_cycle6", qget(pc_log, 5), 64'd2);
    check("t2_store_D", qget(wr_log, 0), wr_ent(32'd100, 32'd5));
    check("t2_retire3_cycle", qget(retire_log, 3), 64'd11);

    // M=M+1 with two wait cycles on each data access.
    enter_reset();
    clear_mem();
    imem[0] = 16'h0064; imem[1] = 16'hFDC8; dmem[100] = 16'd7;
    d_wmin = 2; d_wmax = 2;
    release_reset();
    repeat (20) @(negedge clk);
    check("t3_retire1_cycle", qget(retire_log, 1), 64'd11);
    check("t3_write", qget(wr_log, 0), wr_ent(32'd100, 32'd8));
    check("t3_read_cycles", d_rd_cyc, 3);
    check("t3_write_cycles", d_wr_cyc, 3);

    // Jump conditions.
    enter_reset();
    clear_mem();
    d_wmin = 0; d_wmax = 0;
    imem[0]  = 16'hEE90; imem[1]  = 16'h0028; imem[2]  = 16'hE304;
    imem[40] = 16'hE301; imem[41] = 16'h0032; imem[42] = 16'hEA87;
    imem[50] = 16'hEC08; imem[51] = 16'h0033; imem[52] = 16'hEA87;
    release_reset();
    repeat (40) @(negedge clk);
    exp_fetch = '{64'd0, 64'd1, 64'd2, 64'd40, 64'd41, 64'd42, 64'd50, 64'd51};
    for (int i = 0; i < 8; i++) check($sformatf("t4_fetch%0d", i), qget(fetch_log, i), exp_fetch[i]);
    check("t4_A_after_jmp", qget(wr_log, 0), wr_ent(32'd50, 32'd50));

    // Reset while MWRITE is waiting for ack.
    enter_reset();
    clear_mem();
    imem[0] = 16'h0064; imem[1] = 16'hE308; dmem[100] = 16'h1234;
    d_wmin = 5; d_wmax = 5;
    release_reset();
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (dmem_req && dmem_we) found = 1'b1;
    end
    check("t6_mwrite_reached", found, 1'b1);
    n0 = retire_log.size();
    #1 reset_n = 1'b0;
    #1;
    check("t6_req_drops", {dmem_req, dmem_we, retire}, 3'b000);
    check("t6_pc_vector", pc, 15'd0);
    repeat (3) @(negedge clk);
    check("t6_no_retire", retire_log.size(), n0);
    check("t6_no_write", dmem[100], 16'h1234);

    // Random programs, random wait states, spurious acks, one mid-run reset.
    for (int i = 0; i < (1 << AW); i++) begin
      imem[i] = $urandom_range(1, 0) ? {1'b0, 15'($urandom)} : {1'b1, 15'($urandom)};
      dmem[i] = W'($urandom);
    end
    i_wmin = 0; i_wmax = 3; d_wmin = 0; d_wmax = 3; spurious = 1'b1;
    n0 = n_retire;
    release_reset();
    for (int c = 0; c < 8000 && n_retire < n0 + 200; c++) @(negedge clk);
    check("rand_progress_a", n_retire >= n0 + 200, 1'b1);
    #($urandom_range(3, 1)) reset_n = 1'b0;
    retire_log.delete();
    n0 = n_retire;
    release_reset();
    for (int c = 0; c < 8000 && n_retire < n0 + 300; c++) @(negedge clk);
    check("rand_progress_b", n_retire >= n0 + 300, 1'b1);

    // Width generalisation results from the 24-bit instance.
    check("w24_A_full", qget(wwr_log, 0), wr_ent(32'h10, 32'h7FFFFF));
    check("w24_D_plus1", qget(wwr_log, 1), wr_ent(32'h11, 32'h800000));
    check("w24_ng_jump_and_minus1", qget(wwr_log, 2), wr_ent(32'h12, 32'hFFFFFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_cpu_mc.md
# hack_cpu_mc

Multi-cycle, parametrised Hack CPU. Executes Hack machine code through a fetch/decode/execute state machine and reaches instruction and data memory over separate request/acknowledge handshakes, so wait-state memories (SRAM, SPI flash, peripherals) can sit behind it. It is the width-generalised, stall-capable successor to the single-cycle CPU. It sits between the instruction ROM port and the data RAM/MMIO bus of the computer top level.

## Interface
- WIDTH, 16: data, register and instruction width (≥16).
- ADDR_W, 15: instruction and data address width (≤ WIDTH-1).
- RESET_VECTOR, 0: PC value loaded on reset.

- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (= PC).
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  WIDTH  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = write, 0 = read; valid while dmem_req=1.
- dmem_addr  out  ADDR_W  data address.
- dmem_wdata  out  WIDTH  write data.
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle on reads.
- dmem_rdata  in  WIDTH  read data.
- pc  out  ADDR_W  current PC.
- retire  out  1  one-cycle pulse per completed instruction.

## Operation
- Registers: A, D (WIDTH), PC (ADDR_W), IR (WIDTH), MDR (WIDTH), WADDR (ADDR_W), WDATA (WIDTH), state.
- Encoding: IR[WIDTH-1]=0 is an A-instruction. The A-instruction loads A with IR and bit WIDTH-1 cleared.
- C-instruction fields: a=IR[12], zx..no=IR[11:6], d1(A)=IR[5], d2(D)=IR[4], d3(M)=IR[3], j1..j3=IR[2:0]. Bits WIDTH-2..13 are ignored.
- ALU: standard Hack zx/nx/zy/ny/f/no. Arithmetic is modulo 2^WIDTH. x=D; y=A when a=0, MDR when a=1.
- Flags: zr = (out==0); ng = out[WIDTH-1].
- jump = (j1&ng) | (j2&zr) | (j3&~zr&~ng).
- States:
  - FETCH: imem_req=1, imem_addr=PC. On imem_ack: IR←imem_rdata, go to DECODE.
  - DECODE: A-instruction → A←IR (MSB cleared), PC←PC+1, retire=1, go to FETCH. C-instruction with a=1 → MREAD. Otherwise → EXEC.
  - MREAD: dmem_req=1, dmem_we=0, dmem_addr=A[ADDR_W-1:0]. On dmem_ack: MDR←dmem_rdata, go to EXEC.
  - EXEC: the ALU uses the pre-update A and D.
    - If d1: A←out. If d2: D←out.
    - PC←A[ADDR_W-1:0] (old A) if jump, else PC+1.
    - If d3: WADDR←old A[ADDR_W-1:0], WDATA←out, go to MWRITE.
    - Otherwise retire=1, go to FETCH.
  - MWRITE: dmem_req=1, dmem_we=1, dmem_addr=WADDR, dmem_wdata=WDATA. On dmem_ack: retire=1, go to FETCH.
- PC increment wraps modulo 2^ADDR_W.
- A jump target uses the low ADDR_W bits of A.

## Timing
- Reset (asynchronous, reset_n=0):
  - state=FETCH, PC=RESET_VECTOR; A, D, IR, MDR, WADDR, WDATA = 0.
  - imem_req, dmem_req, dmem_we and retire are forced to 0 while reset_n=0.
  - The first fetch request is asserted in the first cycle after release.
- Handshake rules:
  - A request and its addr/we/wdata are held stable from assertion until the cycle ack is sampled high.
  - Ack may arrive in the same cycle as the request (zero wait). The transfer completes on that edge.
  - Ack is ignored when the matching request is low.
  - At most one of imem_req and dmem_req is high in any cycle.
- Reset mid-transaction: the request drops immediately and no state is committed. The memory side must tolerate an abandoned request.
- Cycles with zero-wait memory:
  - A-instruction: 2.
  - C-instruction, no M access: 3.
  - C-instruction with M read only, or M write only: 4.
  - C-instruction with M read and M write: 5.
  - Each ack wait cycle adds 1.
- retire is high exactly one cycle per instruction. pc shows the updated value from the cycle after retire.
- dmem_wdata and dmem_addr during MWRITE come from registers and do not depend on current A or D.

## Test plan
- Reset/first fetch: hold reset_n=0 for 3 cycles, then release → imem_req=1, imem_addr=0 in the first cycle after release; all other outputs 0 during reset.
- A-instruction then D=A: program 0x0005, 0xEC10 with zero-wait memory → D=5 after 5 cycles; retire pulses in cycles 2 and 5; PC=2.
- M read/write with waits: A=100, MEM[100]=7, instruction M=M+1 (0xFDC8), dmem_ack delayed 2 cycles each access → write of 8 to address 100; request and address stable during waits; 9 cycles total.
- Jump conditions: D=0xFFFF (WIDTH=16), A=40, D;JLT → PC=40. D;JGT → PC+1. 0;JMP → PC=40 with A unchanged.
- Width generalisation: WIDTH=24, ADDR_W=20, A-instruction 0x7FFFFF → A=0x7FFFFF. D=A then D=D+1 → D=0x800000 and ng=1; -1 wraps to 0xFFFFFF.
- Reset mid-MWRITE: assert reset_n=0 while dmem_req=1, dmem_we=1 → dmem_req falls with no edge needed; PC=RESET_VECTOR; no retire pulse.
